// File: rtl/i2s_stereo_rx.sv
// Stereo I2S / left-justified receiver: pairs left+right slot words into frames
// and buffers them in a small FIFO with a valid/ready output, all on aud_bclk.
module i2s_stereo_rx #(
  parameter int WL         = 24,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SIGN_EXT   = 1,
  parameter bit LRC_LEFT   = 1'b0
) (
  input  logic        aud_bclk,
  input  logic        rst,
  input  logic        aud_lrc,
  input  logic        aud_adcdat,
  input  logic        fmt_lj,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_left,
  output logic [31:0] out_right,
  output logic        short_err,
  output logic [15:0] overrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (WL < 8 || WL > 32 || SLOT_W < WL || SLOT_W > 63 || FIFO_DEPTH < 2 ||
      (1 << AW) != FIFO_DEPTH) begin : g_cfg_check
    $error("i2s_stereo_rx: unsupported WL/SLOT_W/FIFO_DEPTH");
  end

  function automatic logic [31:0] fmt_word(input logic [WL-1:0] w);
    if (SIGN_EXT != 0) return 32'($signed(w));
    return 32'(w) << (32 - WL);
  endfunction

  logic          lrc_d;
  logic [5:0]    bit_cnt;
  logic [WL-2:0] sh;
  logic          d_reg;
  logic          armed;
  logic          pair;
  logic          got_word;
  logic [31:0]   left_hold;
  logic          push_pend;
  logic [63:0]   push_data;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [63:0]   mem [FIFO_DEPTH];

  logic          lrc_edge, slot_left, d_cur, in_word, done;
  logic [5:0]    cur_k, last_k;
  logic [WL-1:0] word;
  logic          empty, full, pop, wr_en;

  assign lrc_edge  = aud_lrc ^ lrc_d;
  assign slot_left = (aud_lrc == LRC_LEFT);
  // Format is latched only on a left edge so a frame never mixes formats.
  assign d_cur     = (lrc_edge && slot_left) ? ~fmt_lj : d_reg;
  assign cur_k     = lrc_edge ? 6'd0 : bit_cnt;
  assign last_k    = 6'(WL - 1) + 6'(d_cur);
  assign in_word   = (cur_k >= 6'(d_cur)) && (cur_k <= last_k);
  assign done      = (cur_k == last_k);
  assign word      = {sh, aud_adcdat};
  assign short_err = ~rst & lrc_edge & armed & ~got_word;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign wr_en     = push_pend & (~full | pop);
  assign out_left  = out_valid ? mem[rd_ptr[AW-1:0]][63:32] : 32'd0;
  assign out_right = out_valid ? mem[rd_ptr[AW-1:0]][31:0]  : 32'd0;

  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      lrc_d       <= LRC_LEFT;
      bit_cnt     <= '0;
      sh          <= '0;
      d_reg       <= 1'b1;
      armed       <= 1'b0;
      pair        <= 1'b0;
      got_word    <= 1'b0;
      left_hold   <= '0;
      push_pend   <= 1'b0;
      push_data   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overrun_cnt <= '0;
    end else begin
      lrc_d     <= aud_lrc;
      bit_cnt   <= (cur_k == 6'd63) ? 6'd63 : cur_k + 6'd1;
      push_pend <= 1'b0;
      if (lrc_edge && slot_left) begin
        d_reg <= ~fmt_lj;
        armed <= 1'b1;
      end
      if (in_word) sh <= word[WL-2:0];
      if (lrc_edge) got_word <= 1'b0;
      else if (done) got_word <= 1'b1;
      if (short_err) pair <= 1'b0;
      if (done && armed) begin
        if (slot_left) begin
          left_hold <= fmt_word(word);
          pair      <= 1'b1;
        end else if (pair) begin
          push_data <= {left_hold, fmt_word(word)};
          push_pend <= 1'b1;
          pair      <= 1'b0;
        end
      end
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push_pend && !wr_en && overrun_cnt != 16'hFFFF)
        overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

  always_ff @(posedge aud_bclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_i2s_stereo_rx.sv
// Bench for i2s_stereo_rx: two instances (sign-extended and left-aligned) share one
// serial stream; a slot-level model predicts frames, short slots and overruns.
module tb_i2s_stereo_rx;
  localparam int WL = 24;
  localparam int DEPTH = 4;

  logic aud_bclk = 1'b0, rst = 1'b1, aud_lrc = 1'b0, aud_adcdat = 1'b0;
  logic fmt_lj = 1'b0, out_ready = 1'b1;
  logic ov_a, ov_b, se_a, se_b;
  logic [31:0] ol_a, or_a, ol_b, or_b;
  logic [15:0] oc_a, oc_b;

  i2s_stereo_rx #(.WL(WL), .SLOT_W(32), .FIFO_DEPTH(DEPTH), .SIGN_EXT(1), .LRC_LEFT(1'b0)) dut_a (
    .aud_bclk(aud_bclk), .rst(rst), .aud_lrc(aud_lrc), .aud_adcdat(aud_adcdat), .fmt_lj(fmt_lj),
    .out_valid(ov_a), .out_ready(out_ready), .out_left(ol_a), .out_right(or_a),
    .short_err(se_a), .overrun_cnt(oc_a));
  i2s_stereo_rx #(.WL(WL), .SLOT_W(32), .FIFO_DEPTH(DEPTH), .SIGN_EXT(0), .LRC_LEFT(1'b0)) dut_b (
    .aud_bclk(aud_bclk), .rst(rst), .aud_lrc(aud_lrc), .aud_adcdat(aud_adcdat), .fmt_lj(fmt_lj),
    .out_valid(ov_b), .out_ready(out_ready), .out_left(ol_b), .out_right(or_b),
    .short_err(se_b), .overrun_cnt(oc_b));

  always #5 aud_bclk = ~aud_bclk;

  typedef struct {
    logic        fmt;
    logic [23:0] l, r;
    logic [31:0] el_se, er_se, el_lj, er_lj;
  } vec_t;
  vec_t vecs[4];

  int checks = 0, failures = 0;
  int short_seen_a = 0, short_seen_b = 0, short_exp = 0;
  int frames_seen = 0, valid_cnt = 0;
  logic lat_en = 1'b0, rnd_ready = 1'b0;
  time lsb_time = 0;
  logic [31:0] last_l_a, last_r_a, last_l_b, last_r_b;

  // slot-level reference model
  logic [47:0] mq[$];
  logic m_armed, m_pair, m_cur_done, m_last_lrc;
  logic [23:0] m_left;
  int m_d, m_overrun;
  logic [47:0] mon_f;
  logic [23:0] mon_l, mon_r;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fse(input logic [23:0] w);
    return 32'($signed(w));
  endfunction
  function automatic logic [31:0] flj(input logic [23:0] w);
    return {w, 8'h00};
  endfunction

  always @(negedge aud_bclk) begin
    #4;
    if (!rst) begin
      if (se_a) short_seen_a++;
      if (se_b) short_seen_b++;
      if (ov_a) valid_cnt++;
      if (lat_en && ov_a) begin
        lat_en = 1'b0;
        chk32("latency", 32'($time - lsb_time), 32'd24);
      end
      if (ov_a && out_ready) begin
        frames_seen++;
        chk32("valid_b", {31'b0, ov_b}, 32'd1);
        if (mq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame actual=%h_%h required=none", ol_a, or_a);
        end else begin
          mon_f = mq.pop_front();
          mon_l = mon_f[47:24];
          mon_r = mon_f[23:0];
          chk32("left_se", ol_a, fse(mon_l));
          chk32("right_se", or_a, fse(mon_r));
          chk32("left_lj", ol_b, flj(mon_l));
          chk32("right_lj", or_b, flj(mon_r));
        end
        last_l_a = ol_a; last_r_a = or_a; last_l_b = ol_b; last_r_b = or_b;
      end
    end
  end

  task automatic model_edge(input logic lrc);
    if (m_armed && !m_cur_done) begin
      short_exp++;
      m_pair = 1'b0;
    end
    m_cur_done = 1'b0;
    if (lrc == 1'b0) begin
      m_armed = 1'b1;
      m_d = fmt_lj ? 0 : 1;
    end
  endtask

  task automatic model_complete(input logic lrc, input logic [23:0] w);
    m_cur_done = 1'b1;
    if (m_armed) begin
      if (lrc == 1'b0) begin
        m_left = w;
        m_pair = 1'b1;
      end else if (m_pair) begin
        m_pair = 1'b0;
        lsb_time = $time;
        if (mq.size() >= DEPTH) m_overrun++;
        else mq.push_back({m_left, w});
      end
    end
  endtask

  task automatic send_slot(input logic lrc, input logic [23:0] w, input int nbits, input int tog_k);
    int idx;
    for (int k = 0; k < nbits; k++) begin
      @(negedge aud_bclk);
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      if (k == tog_k) fmt_lj = ~fmt_lj;
      aud_lrc = lrc;
      if (k == 0 && lrc != m_last_lrc) model_edge(lrc);
      m_last_lrc = lrc;
      if (k >= m_d && k < m_d + WL) begin
        idx = WL - 1 - (k - m_d);
        aud_adcdat = w[idx];
      end else begin
        aud_adcdat = 1'($urandom);
      end
      if (k == m_d + WL - 1) model_complete(lrc, w);
    end
  endtask

  task automatic send_frame(input logic fmt, input logic [23:0] l, input logic [23:0] r,
                            input int nl, input int nr, input int tog_k);
    fmt_lj = fmt;
    send_slot(1'b0, l, nl, tog_k);
    send_slot(1'b1, r, nr, -1);
  endtask

  task automatic do_reset();
    @(negedge aud_bclk);
    rst = 1'b1;
    @(negedge aud_bclk);
    rst = 1'b0;
    mq.delete();
    m_armed = 1'b0; m_pair = 1'b0; m_cur_done = 1'b0; m_last_lrc = 1'b0;
    m_d = 1; m_overrun = 0;
    #4;
    chk32("rst_valid", {31'b0, ov_a}, 32'd0);
    chk32("rst_left", ol_a, 32'd0);
    chk32("rst_right", or_b, 32'd0);
    chk32("rst_short", {31'b0, se_a}, 32'd0);
    chk32("rst_overrun_a", {16'b0, oc_a}, 32'd0);
    chk32("rst_overrun_b", {16'b0, oc_b}, 32'd0);
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 300 && mq.size() != 0; i++) @(negedge aud_bclk);
    repeat (4) @(negedge aud_bclk);
    chk32(name, mq.size(), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int s0, f0;
    vecs[0] = '{1'b0, 24'h800001, 24'h7FFFFF, 32'hFF800001, 32'h007FFFFF, 32'h80000100, 32'h7FFFFF00};
    vecs[1] = '{1'b1, 24'hA5A5A5, 24'h123456, 32'hFFA5A5A5, 32'h00123456, 32'hA5A5A500, 32'h12345600};
    vecs[2] = '{1'b0, 24'h000000, 24'hFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFF00};
    vecs[3] = '{1'b1, 24'h7FFFFF, 24'h800000, 32'h007FFFFF, 32'hFF800000, 32'h7FFFFF00, 32'h80000000};

    do_reset();
    // stream starts mid-right-slot: nothing until a full left+right pair
    send_slot(1'b1, 24'($urandom), 10, -1);

    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin valid_cnt = 0; lat_en = 1'b1; end
      send_frame(vecs[i].fmt, vecs[i].l, vecs[i].r, 32, 32, (i == 1) ? 5 : -1);
      repeat (6) @(negedge aud_bclk);
      chk32("vec_left_se", last_l_a, vecs[i].el_se);
      chk32("vec_right_se", last_r_a, vecs[i].er_se);
      chk32("vec_left_lj", last_l_b, vecs[i].el_lj);
      chk32("vec_right_lj", last_r_b, vecs[i].er_lj);
      if (i == 0) begin
        chk32("valid_one_cycle", valid_cnt, 32'd1);
        chk32("latency_seen", {31'b0, lat_en}, 32'd0);
      end
    end

    // short left slot: one pulse, following right discarded, next frame fine
    s0 = short_seen_a; f0 = frames_seen;
    send_slot(1'b0, 24'($urandom), 10, -1);
    send_slot(1'b1, 24'($urandom), 32, -1);
    send_frame(vecs[2].fmt, vecs[2].l, vecs[2].r, 32, 32, -1);
    repeat (6) @(negedge aud_bclk);
    chk32("short_pulses", short_seen_a - s0, 32'd1);
    chk32("short_frames", frames_seen - f0, 32'd1);
    chk32("short_next_left", last_l_a, vecs[2].el_se);
    chk32("short_next_right", last_r_b, vecs[2].er_lj);

    // overrun: 6 frames into a 4-deep FIFO with ready low
    out_ready = 1'b0;
    f0 = frames_seen;
    for (int i = 0; i < 6; i++) send_frame(1'($urandom), 24'($urandom), 24'($urandom), 32, 32, -1);
    repeat (4) @(negedge aud_bclk);
    chk32("overrun_a", {16'b0, oc_a}, 32'd2);
    chk32("overrun_b", {16'b0, oc_b}, 32'(m_overrun));
    chk32("full_valid", {31'b0, ov_a}, 32'd1);
    drain("overrun_drain");
    chk32("overrun_frames", frames_seen - f0, 32'd4);

    // reset with buffered frames and a half-captured word
    out_ready = 1'b0;
    send_frame(1'b0, 24'h111111, 24'h222222, 32, 32, -1);
    send_frame(1'b1, 24'h333333, 24'h444444, 32, 32, -1);
    send_slot(1'b0, 24'h555555, 12, -1);
    do_reset();
    out_ready = 1'b1;
    send_slot(1'b1, 24'($urandom), 20, -1);
    send_frame(vecs[3].fmt, vecs[3].l, vecs[3].r, 32, 32, -1);
    repeat (6) @(negedge aud_bclk);
    chk32("post_rst_left", last_l_a, vecs[3].el_se);
    chk32("post_rst_right", last_r_b, vecs[3].er_lj);

    // randomized stream: random words, formats, slot lengths and ready
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send_frame(1'($urandom), 24'($urandom), 24'($urandom),
                 $urandom_range(20, 40), $urandom_range(20, 40), -1);
    rnd_ready = 1'b0;
    drain("random_drain");
    chk32("short_total_a", short_seen_a, 32'(short_exp));
    chk32("short_total_b", short_seen_b, 32'(short_exp));
    chk32("overrun_final", {16'b0, oc_a}, 32'(m_overrun));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
